sprite_plotter: RTL and testbench

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_scan_counter.sv | 41 ++++
 rtl/sprite_plotter.sv | 174 +++++++++++++++++
 tb/tb_sprite_plotter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite plotter: FSM states, colours and
// the slot geometry used to place sprites along the conveyor.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLOT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_PRESS = 3'b110;
    localparam logic [2:0] COL_GARB  = 3'b010;

    localparam logic [7:0] SLOT_PITCH = 8'd24;
    localparam logic [7:0] SLOT_BASE  = 8'd16;
    localparam logic [7:0] GARB_XOFF  = 8'd4;
    localparam logic [2:0] MAX_POS    = 3'd5;

    // Left edge of a slot; only meaningful for pos <= MAX_POS.
    function automatic logic [7:0] slot_x(input logic [2:0] pos);
        return SLOT_BASE + SLOT_PITCH * {5'd0, pos};
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major x/y offset counter for a W x H sprite; exposes the next offsets
// so the caller can register pixel coordinates one cycle ahead.
module sprite_scan_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] w,
    input  logic [6:0] h,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] ox,
    output logic [6:0] oy,
    output logic [7:0] ox_next,
    output logic [6:0] oy_next,
    output logic       last
);

    logic row_end;

    assign row_end = (ox == w - 8'd1);
    assign last    = row_end && (oy == h - 7'd1);

    always_comb begin
        ox_next = ox + 8'd1;
        oy_next = oy;
        if (row_end) begin
            ox_next = 8'd0;
            oy_next = oy + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ox <= 8'd0;
            oy <= 7'd0;
        end else if (inc) begin
            ox <= ox_next;
            oy <= oy_next;
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// Draws or erases a press/garbage sprite in one of six slots, one pixel per
// cycle. Define SPRITE_PLOTTER_QUEUE_EN to add a one-entry command buffer.
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int PRESS_W = 16,
    parameter int PRESS_H = 12,
    parameter int GARB_W  = 8,
    parameter int GARB_H  = 8,
    parameter int PRESS_Y = 20,
    parameter int GARB_Y  = 90
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       item,
    input  logic       erase,
    input  logic [2:0] position,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    state_t     state, state_n;
    logic       cmd_item, cmd_erase;
    logic [2:0] cmd_pos;
    logic       load_in, cnt_clear, cnt_inc;
    logic       pos_valid, last;
    logic [7:0] dim_w, base_x, ox, ox_next;
    logic [6:0] dim_h, base_y, oy, oy_next;
    logic [2:0] cmd_col;

`ifdef SPRITE_PLOTTER_QUEUE_EN
    logic       q_full, q_item, q_erase, load_q, q_store;
    logic [2:0] q_pos;
    assign ready = !q_full;
`else
    assign ready = (state == IDLE);
`endif

    assign busy = (state != IDLE);
    assign plot = (state == PLOT);
    assign done = (state == DONE);

    // Geometry and colour of the latched command.
    assign pos_valid = (cmd_pos <= MAX_POS);
    assign dim_w     = cmd_item ? 8'(PRESS_W) : 8'(GARB_W);
    assign dim_h     = cmd_item ? 7'(PRESS_H) : 7'(GARB_H);
    assign base_x    = slot_x(cmd_pos) + (cmd_item ? 8'd0 : GARB_XOFF);
    assign base_y    = cmd_item ? 7'(PRESS_Y) : 7'(GARB_Y);
    assign cmd_col   = cmd_erase ? COL_BLACK : (cmd_item ? COL_PRESS : COL_GARB);

    sprite_scan_counter u_scan (
        .clk     (CLOCK_50),
        .reset   (reset),
        .w       (dim_w),
        .h       (dim_h),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .ox      (ox),
        .oy      (oy),
        .ox_next (ox_next),
        .oy_next (oy_next),
        .last    (last)
    );

    always_comb begin
        state_n   = state;
        load_in   = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
`ifdef SPRITE_PLOTTER_QUEUE_EN
        load_q    = 1'b0;
        q_store   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && ready) begin
                    state_n = LOAD;
                    load_in = 1'b1;
                end
            end
            LOAD: begin
                cnt_clear = 1'b1;
                state_n   = pos_valid ? PLOT : DONE;
`ifdef SPRITE_PLOTTER_QUEUE_EN
                q_store   = start && ready;
`endif
            end
            PLOT: begin
                if (last) state_n = DONE;
                else      cnt_inc = 1'b1;
`ifdef SPRITE_PLOTTER_QUEUE_EN
                q_store   = start && ready;
`endif
            end
            DONE: begin
`ifdef SPRITE_PLOTTER_QUEUE_EN
                // A buffered command chains straight into LOAD; with an empty
                // buffer a fresh start is taken directly.
                if (q_full) begin
                    state_n = LOAD;
                    load_q  = 1'b1;
                end else if (start) begin
                    state_n = LOAD;
                    load_in = 1'b1;
                end else begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cmd_item  <= 1'b0;
            cmd_erase <= 1'b0;
            cmd_pos   <= 3'd0;
        end else if (load_in) begin
            cmd_item  <= item;
            cmd_erase <= erase;
            cmd_pos   <= position;
`ifdef SPRITE_PLOTTER_QUEUE_EN
        end else if (load_q) begin
            cmd_item  <= q_item;
            cmd_erase <= q_erase;
            cmd_pos   <= q_pos;
`endif
        end
    end

`ifdef SPRITE_PLOTTER_QUEUE_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset || load_q) begin
            q_full <= 1'b0;
        end else if (q_store) begin
            q_full  <= 1'b1;
            q_item  <= item;
            q_erase <= erase;
            q_pos   <= position;
        end
    end
`endif

    // Coordinates are registered one cycle ahead so they hold outside PLOT.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= COL_BLACK;
        end else if (state == LOAD && pos_valid) begin
            x      <= base_x;
            y      <= base_y;
            colour <= cmd_col;
        end else if (state == PLOT && !last) begin
            x      <= base_x + ox_next;
            y      <= base_y + oy_next;
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed, table-driven bench for sprite_plotter: draw/erase vectors plus
// hand-written reset and busy-start sequences.
module tb_sprite_plotter;

    logic       clk = 1'b0;
    logic       reset, start, item, erase;
    logic [2:0] position;
    logic       ready, busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_plotter dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .item     (item),
        .erase    (erase),
        .position (position),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot)
    );

    typedef struct {
        logic       it;
        logic       er;
        logic [2:0] pos;
        int         plots;
        int         first;
        int         donec;
        int         xmin;
        int         xmax;
        int         ymin;
        int         ymax;
        int         col;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a command for one accepting edge, then scramble the inputs.
    task automatic issue(input logic it, input logic er, input logic [2:0] pos, input string tag);
        @(negedge clk);
        check({tag, ".ready_before"}, int'(ready), 1);
        item = it; erase = er; position = pos; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; item = ~it; erase = ~er; position = pos ^ 3'b101;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int np = 0, first = -1, dn = -1, colbad = 0, orderbad = 0;
        int xmn = 999, xmx = -1, ymn = 999, ymx = -1;
        int w;
        w = v.it ? 16 : 8;
        issue(v.it, v.er, v.pos, tag);
        for (int k = 1; k <= 300 && dn < 0; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, ".busy_load"}, int'(busy), 1);
            if (plot) begin
                if (first < 0) first = k;
                if (int'(x) != v.xmin + np % w || int'(y) != v.ymin + np / w) orderbad++;
                if (int'(colour) != v.col) colbad++;
                if (int'(x) < xmn) xmn = int'(x);
                if (int'(x) > xmx) xmx = int'(x);
                if (int'(y) < ymn) ymn = int'(y);
                if (int'(y) > ymx) ymx = int'(y);
                np++;
            end
            if (done) dn = k;
        end
        check({tag, ".plots"}, np, v.plots);
        check({tag, ".done_cycle"}, dn, v.donec);
        if (v.plots > 0) begin
            check({tag, ".first_plot"}, first, v.first);
            check({tag, ".xmin"}, xmn, v.xmin);
            check({tag, ".xmax"}, xmx, v.xmax);
            check({tag, ".ymin"}, ymn, v.ymin);
            check({tag, ".ymax"}, ymx, v.ymax);
            check({tag, ".colour_bad"}, colbad, 0);
            check({tag, ".order_bad"}, orderbad, 0);
            check({tag, ".x_hold"}, int'(x), v.xmax);
            check({tag, ".y_hold"}, int'(y), v.ymax);
        end
        @(negedge clk);
        check({tag, ".ready_after"}, int'(ready), 1);
        check({tag, ".busy_after"}, int'(busy), 0);
        check({tag, ".plot_after"}, int'(plot), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int np, nd, nb;
        vecs[0] = '{1'b1, 1'b0, 3'd2, 192, 2, 194,  64,  79, 20, 31, 6};
        vecs[1] = '{1'b0, 1'b1, 3'd3,  64, 2,  66,  92,  99, 90, 97, 0};
        vecs[2] = '{1'b0, 1'b0, 3'd7,   0, 0,   2,   0,   0,  0,  0, 0};
        vecs[3] = '{1'b1, 1'b0, 3'd5, 192, 2, 194, 136, 151, 20, 31, 6};
        vecs[4] = '{1'b0, 1'b0, 3'd0,  64, 2,  66,  20,  27, 90, 97, 2};
        vecs[5] = '{1'b1, 1'b0, 3'd6,   0, 0,   2,   0,   0,  0,  0, 0};
        vecs[6] = '{1'b1, 1'b1, 3'd0, 192, 2, 194,  16,  31, 20, 31, 0};

        reset = 1'b1; start = 1'b0; item = 1'b0; erase = 1'b0; position = 3'd0;
        repeat (3) @(negedge clk);
        check("rst.ready", int'(ready), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.plot", int'(plot), 0);
        check("rst.done", int'(done), 0);
        check("rst.x", int'(x), 0);
        check("rst.y", int'(y), 0);
        check("rst.colour", int'(colour), 0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset on the 50th plot of a press draw.
        issue(1'b1, 1'b0, 3'd2, "midrst");
        np = 0;
        for (int k = 1; k <= 300 && np < 50; k++) begin
            @(negedge clk);
            if (plot) np++;
        end
        check("midrst.reached50", np, 50);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.plot", int'(plot), 0);
        check("midrst.ready", int'(ready), 1);
        check("midrst.busy", int'(busy), 0);
        check("midrst.done", int'(done), 0);
        check("midrst.x", int'(x), 0);
        check("midrst.colour", int'(colour), 0);
        np = 0; nd = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (plot) np++;
            if (done) nd++;
        end
        check("midrst.later_plots", np, 0);
        check("midrst.later_dones", nd, 0);

        // Start coinciding with reset is discarded.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; item = 1'b1; position = 3'd1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("rststart.busy_cycles", nb, 0);

        // Second start arrives at N+10 during a garbage draw.
        issue(1'b0, 1'b0, 3'd1, "busystart");
        np = 0; nd = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (plot) np++;
            if (done) nd++;
            if (k == 9) begin
                start = 1'b1; item = 1'b1; erase = 1'b0; position = 3'd0;
            end else if (k == 10) begin
                start = 1'b0;
            end
        end
`ifdef SPRITE_PLOTTER_QUEUE_EN
        check("busystart.plots", np, 64 + 192);
        check("busystart.dones", nd, 2);
`else
        check("busystart.plots", np, 64);
        check("busystart.dones", nd, 1);
`endif
        check("busystart.idle_end", int'(ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
